instr_mem_sync: RTL and testbench

- Parametrised, synchronous-read instruction memory for the IF stage of the 5-stage RV32I pipeline.
- Registers the fetched word directly into the IF/ID boundary: InstrD, plus a valid flag.
- Supports StallF hold, FlushD bubble insertion and misaligned/out-of-range fetch faults.
- A streaming program-load port fills memory at runtime, replacing the fixed initial program image.

---
 rtl/instr_mem_sync_if.sv | 45 ++++
 rtl/instr_mem_sync.sv | 129 ++++++++++++
 tb/tb_instr_mem_sync.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_sync_if.sv
// Fetch (IF/ID) and program-load bus for instr_mem_sync.
// When IMEM_PARITY_EN is defined, the bus also carries InstrParityErrD.
interface instr_mem_sync_if #(
  parameter int DEPTH = 1024
) ();
  localparam int AW = $clog2(DEPTH);

  logic [31:0]   PCF;
  logic          StallF;
  logic          FlushD;
  logic [31:0]   InstrD;
  logic          InstrValidD;
  logic          FetchFaultD;
`ifdef IMEM_PARITY_EN
  logic          InstrParityErrD;
`endif
  logic          load_start;
  logic [AW-1:0] load_base;
  logic [AW:0]   load_len;
  logic          load_valid;
  logic [31:0]   load_data;
  logic          load_ready;
  logic          load_busy;
  logic          load_done;

`ifdef IMEM_PARITY_EN
  modport master (
    output PCF, StallF, FlushD, load_start, load_base, load_len, load_valid, load_data,
    input  InstrD, InstrValidD, FetchFaultD, InstrParityErrD, load_ready, load_busy, load_done
  );
  modport slave (
    input  PCF, StallF, FlushD, load_start, load_base, load_len, load_valid, load_data,
    output InstrD, InstrValidD, FetchFaultD, InstrParityErrD, load_ready, load_busy, load_done
  );
`else
  modport master (
    output PCF, StallF, FlushD, load_start, load_base, load_len, load_valid, load_data,
    input  InstrD, InstrValidD, FetchFaultD, load_ready, load_busy, load_done
  );
  modport slave (
    input  PCF, StallF, FlushD, load_start, load_base, load_len, load_valid, load_data,
    output InstrD, InstrValidD, FetchFaultD, load_ready, load_busy, load_done
  );
`endif
endinterface

// File: rtl/instr_mem_sync.sv
// Synchronous-read instruction memory registering straight into IF/ID, with a streaming
// program-load port. Optional per-word even parity checking under IMEM_PARITY_EN.
module instr_mem_sync #(
  parameter int          DEPTH      = 1024,
  parameter logic [31:0] NOP_INSTR  = 32'h00000013,
  parameter int          RESET_BASE = 0
) (
  input logic             clk,
  input logic             rst,
  instr_mem_sync_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t        state;
  logic [AW-1:0] base;
  logic [AW:0]   len;
  logic [AW:0]   cnt;
  logic [31:0]   mem [DEPTH];

  logic [AW-1:0] waddr;
  logic [AW-1:0] raddr;
  logic          wr_en;
  logic          fetch_fault;

  // Load address wraps naturally through the AW-bit truncation.
  assign waddr       = base + cnt[AW-1:0];
  assign wr_en       = !rst && (state == LOAD) && bus.load_valid && bus.load_ready;
  assign raddr       = bus.PCF[AW+1:2];
  assign fetch_fault = (bus.PCF[1:0] != 2'b00) || ({2'b00, bus.PCF[31:2]} >= 32'(DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      base           <= AW'(RESET_BASE);
      len            <= '0;
      cnt            <= '0;
      bus.load_ready <= 1'b0;
      bus.load_busy  <= 1'b0;
      bus.load_done  <= 1'b0;
    end else begin
      bus.load_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.load_start && (bus.load_len != '0)) begin
            state          <= LOAD;
            base           <= bus.load_base;
            len            <= bus.load_len;
            cnt            <= '0;
            bus.load_ready <= 1'b1;
            bus.load_busy  <= 1'b1;
          end
        end
        LOAD: begin
          if (wr_en) begin
            cnt <= cnt + (AW+1)'(1);
            if (cnt == len - (AW+1)'(1)) begin
              state          <= DONE;
              bus.load_ready <= 1'b0;
              bus.load_done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state         <= IDLE;
          bus.load_busy <= 1'b0;
        end
        default: begin
          state          <= IDLE;
          bus.load_ready <= 1'b0;
          bus.load_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Array is deliberately not reset so a loaded program survives rst.
  always_ff @(posedge clk) begin
    if (wr_en) mem[waddr] <= bus.load_data;
  end

`ifdef IMEM_PARITY_EN
  logic [DEPTH-1:0] par;
  logic             rd_perr;

  assign rd_perr = (^mem[raddr]) != par[raddr];

  always_ff @(posedge clk) begin
    if (rst)        par        <= '0;
    else if (wr_en) par[waddr] <= ^bus.load_data;
  end
`endif

  // IF/ID boundary register
  always_ff @(posedge clk) begin
    if (rst || (state != IDLE) || bus.FlushD) begin
      bus.InstrD          <= NOP_INSTR;
      bus.InstrValidD     <= 1'b0;
      bus.FetchFaultD     <= 1'b0;
`ifdef IMEM_PARITY_EN
      bus.InstrParityErrD <= 1'b0;
`endif
    end else if (bus.StallF) begin
      bus.InstrD          <= bus.InstrD;
      bus.InstrValidD     <= bus.InstrValidD;
      bus.FetchFaultD     <= bus.FetchFaultD;
`ifdef IMEM_PARITY_EN
      bus.InstrParityErrD <= bus.InstrParityErrD;
`endif
    end else if (fetch_fault) begin
      bus.InstrD          <= NOP_INSTR;
      bus.InstrValidD     <= 1'b0;
      bus.FetchFaultD     <= 1'b1;
`ifdef IMEM_PARITY_EN
      bus.InstrParityErrD <= 1'b0;
`endif
    end else begin
      bus.InstrD          <= mem[raddr];
      bus.FetchFaultD     <= 1'b0;
`ifdef IMEM_PARITY_EN
      bus.InstrValidD     <= !rd_perr;
      bus.InstrParityErrD <= rd_perr;
`else
      bus.InstrValidD     <= 1'b1;
`endif
    end
  end
endmodule

// File: tb/tb_instr_mem_sync.sv
// Directed bench for instr_mem_sync: load, fetch, stall/flush, faults, wrap, reset mid-load.
module tb_instr_mem_sync;
  localparam int DEPTH = 1024;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [31:0] NOP = 32'h00000013;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  instr_mem_sync_if #(.DEPTH(DEPTH)) bus ();

  instr_mem_sync #(.DEPTH(DEPTH), .NOP_INSTR(NOP), .RESET_BASE(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [AW-1:0] b, input int n,
                         input logic [31:0] w0, input logic [31:0] w1,
                         input logic [31:0] w2, input logic [31:0] w3);
    logic [31:0] w [4];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    bus.load_base  = b;
    bus.load_len   = (AW+1)'(n);
    bus.load_start = 1'b1;
    bus.load_valid = 1'b0;
    step();
    bus.load_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.load_data  = w[i];
      bus.load_valid = 1'b1;
      step();
    end
    bus.load_valid = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (bus.InstrD !== NOP) begin errors++; $display("FAIL reset_instr got %h want %h", bus.InstrD, NOP); end
    checks++; if (bus.InstrValidD !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.InstrValidD); end
    checks++; if (bus.FetchFaultD !== 1'b0) begin errors++; $display("FAIL reset_fault got %b want 0", bus.FetchFaultD); end
    checks++; if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", bus.load_ready); end
    checks++; if (bus.load_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.load_busy); end
    checks++; if (bus.load_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.load_done); end
    rst = 1'b0;
  endtask

  task automatic test_load_fetch();
    logic [31:0] w [3];
    w[0] = 32'h00500293; w[1] = 32'h00600313; w[2] = 32'h00000393;
    bus.load_base  = '0;
    bus.load_len   = (AW+1)'(3);
    bus.load_start = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data  = w[0];
    step();
    bus.load_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL load_ready[%0d] got %b want 1", i, bus.load_ready); end
      checks++; if (bus.load_done !== 1'b0) begin errors++; $display("FAIL early_done[%0d] got %b want 0", i, bus.load_done); end
      bus.load_data = w[i];
      step();
    end
    bus.load_valid = 1'b0;
    checks++; if (bus.load_done !== 1'b1) begin errors++; $display("FAIL done_pulse got %b want 1", bus.load_done); end
    checks++; if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL done_ready got %b want 0", bus.load_ready); end
    checks++; if (bus.load_busy !== 1'b1) begin errors++; $display("FAIL done_busy got %b want 1", bus.load_busy); end
    checks++; if (bus.InstrValidD !== 1'b0) begin errors++; $display("FAIL busy_valid got %b want 0", bus.InstrValidD); end
    step();
    checks++; if (bus.load_done !== 1'b0) begin errors++; $display("FAIL done_clear got %b want 0", bus.load_done); end
    checks++; if (bus.load_busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", bus.load_busy); end
    for (int i = 0; i < 3; i++) begin
      bus.PCF = 32'(i * 4);
      step();
      checks++; if (bus.InstrD !== w[i]) begin errors++; $display("FAIL fetch[%0d] got %h want %h", i, bus.InstrD, w[i]); end
      checks++; if (bus.InstrValidD !== 1'b1) begin errors++; $display("FAIL fetch_valid[%0d] got %b want 1", i, bus.InstrValidD); end
    end
  endtask

  task automatic test_stall_flush();
    bus.PCF = 32'h4;
    step();
    bus.StallF = 1'b1;
    bus.PCF    = 32'h8;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (bus.InstrD !== 32'h00600313) begin errors++; $display("FAIL stall_instr[%0d] got %h want 00600313", i, bus.InstrD); end
      checks++; if (bus.InstrValidD !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %b want 1", i, bus.InstrValidD); end
    end
    bus.FlushD = 1'b1;
    step();
    checks++; if (bus.InstrD !== NOP) begin errors++; $display("FAIL flush_instr got %h want %h", bus.InstrD, NOP); end
    checks++; if (bus.InstrValidD !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", bus.InstrValidD); end
    bus.FlushD = 1'b0;
    bus.StallF = 1'b0;
  endtask

  task automatic test_fault();
    bus.PCF = 32'h6;
    step();
    checks++; if (bus.FetchFaultD !== 1'b1) begin errors++; $display("FAIL misalign_fault got %b want 1", bus.FetchFaultD); end
    checks++; if (bus.InstrD !== NOP) begin errors++; $display("FAIL misalign_instr got %h want %h", bus.InstrD, NOP); end
    checks++; if (bus.InstrValidD !== 1'b0) begin errors++; $display("FAIL misalign_valid got %b want 0", bus.InstrValidD); end
    bus.PCF = 32'(DEPTH * 4);
    step();
    checks++; if (bus.FetchFaultD !== 1'b1) begin errors++; $display("FAIL range_fault got %b want 1", bus.FetchFaultD); end
    bus.PCF = 32'h0;
    step();
    checks++; if (bus.FetchFaultD !== 1'b0) begin errors++; $display("FAIL fault_clear got %b want 0", bus.FetchFaultD); end
    checks++; if (bus.InstrD !== 32'h00500293) begin errors++; $display("FAIL after_fault got %h want 00500293", bus.InstrD); end
  endtask

  task automatic test_wrap_load();
    bus.load_base  = AW'(DEPTH - 1);
    bus.load_len   = (AW+1)'(2);
    bus.load_start = 1'b1;
    bus.load_valid = 1'b0;
    step();
    // Competing start held through LOAD and DONE must be ignored.
    bus.load_base  = AW'(7);
    bus.load_len   = (AW+1)'(5);
    bus.load_valid = 1'b1;
    bus.load_data  = 32'hAAAAAAAA;
    step();
    bus.load_data  = 32'hBBBBBBBB;
    step();
    bus.load_valid = 1'b0;
    checks++; if (bus.load_done !== 1'b1) begin errors++; $display("FAIL wrap_done got %b want 1", bus.load_done); end
    step();
    bus.load_start = 1'b0;
    checks++; if (bus.load_busy !== 1'b0) begin errors++; $display("FAIL ignored_start_busy got %b want 0", bus.load_busy); end
    bus.load_len   = '0;
    bus.load_start = 1'b1;
    step();
    bus.load_start = 1'b0;
    checks++; if (bus.load_busy !== 1'b0) begin errors++; $display("FAIL zero_len_busy got %b want 0", bus.load_busy); end
    checks++; if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL zero_len_ready got %b want 0", bus.load_ready); end
    bus.PCF = 32'((DEPTH - 1) * 4);
    step();
    checks++; if (bus.InstrD !== 32'hAAAAAAAA) begin errors++; $display("FAIL wrap_top got %h want aaaaaaaa", bus.InstrD); end
    bus.PCF = 32'h0;
    step();
    checks++; if (bus.InstrD !== 32'hBBBBBBBB) begin errors++; $display("FAIL wrap_zero got %h want bbbbbbbb", bus.InstrD); end
    bus.PCF = 32'h1C;
    step();
    checks++; if (bus.InstrValidD !== 1'b1) begin errors++; $display("FAIL no_stray_load got valid %b want 1", bus.InstrValidD); end
  endtask

  task automatic test_reset_midload();
    logic [31:0] exp [4];
    bus.PCF = 32'h2;
    do_load(AW'(100), 4, 32'hCCCCCCCC, 32'hDDDDDDDD, 32'hEEEEEEEE, 32'h0000000F);
    exp[0] = 32'h11111111; exp[1] = 32'h22222222; exp[2] = 32'hEEEEEEEE; exp[3] = 32'h0000000F;
    bus.load_base  = AW'(100);
    bus.load_len   = (AW+1)'(4);
    bus.load_start = 1'b1;
    step();
    bus.load_start = 1'b0;
    bus.load_valid = 1'b1;
    bus.load_data  = exp[0];
    step();
    bus.load_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    checks++; if (bus.load_busy !== 1'b1) begin errors++; $display("FAIL gap_busy got %b want 1", bus.load_busy); end
    bus.load_valid = 1'b1;
    bus.load_data  = exp[1];
    step();
    bus.load_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (bus.load_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", bus.load_busy); end
    checks++; if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got %b want 0", bus.load_ready); end
    step();
    checks++; if (bus.load_done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b want 0", bus.load_done); end
    for (int i = 0; i < 4; i++) begin
      bus.PCF = 32'((100 + i) * 4);
      step();
      checks++; if (bus.InstrD !== exp[i]) begin errors++; $display("FAIL midrst_word[%0d] got %h want %h", i, bus.InstrD, exp[i]); end
    end
  endtask

`ifdef IMEM_PARITY_EN
  task automatic test_parity();
    do_load(AW'(5), 1, 32'h00000001, 32'h0, 32'h0, 32'h0);
    bus.PCF = 32'h14;
    step();
    checks++; if (bus.InstrParityErrD !== 1'b0) begin errors++; $display("FAIL parity_clean got %b want 0", bus.InstrParityErrD); end
    dut.mem[5] = 32'h00000003;
    step();
    checks++; if (bus.InstrParityErrD !== 1'b1) begin errors++; $display("FAIL parity_err got %b want 1", bus.InstrParityErrD); end
    checks++; if (bus.InstrValidD !== 1'b0) begin errors++; $display("FAIL parity_valid got %b want 0", bus.InstrValidD); end
    checks++; if (bus.InstrD !== 32'h00000003) begin errors++; $display("FAIL parity_raw got %h want 00000003", bus.InstrD); end
  endtask
`endif

  initial begin
    checks         = 0;
    errors         = 0;
    rst            = 1'b1;
    bus.PCF        = 32'h2;
    bus.StallF     = 1'b0;
    bus.FlushD     = 1'b0;
    bus.load_start = 1'b0;
    bus.load_base  = '0;
    bus.load_len   = '0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    test_reset();
    test_load_fetch();
    test_stall_flush();
    test_fault();
    test_wrap_load();
    test_reset_midload();
`ifdef IMEM_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
